// File: rtl/adder_pkg.sv
// Shared types and default sizing for the serial chunk adder.
package adder_pkg;

  localparam int unsigned DEFAULT_WIDTH = 32;
  localparam int unsigned DEFAULT_CHUNK = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/chunk_adder.sv
// One CHUNK-bit ripple slice: sum, carry out and the carry into its MSB.
module chunk_adder #(
  parameter int unsigned CHUNK = 8
) (
  input  logic [CHUNK-1:0] x,
  input  logic [CHUNK-1:0] y,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co,
  output logic             c_msb
);

  localparam int unsigned FW = CHUNK + 1;

  logic [CHUNK:0] full;

  always_comb begin
    full  = {1'b0, x} + {1'b0, y} + FW'(ci);
    s     = full[CHUNK-1:0];
    co    = full[CHUNK];
    // Carry into the MSB falls out of the MSB sum bit and its two operand bits.
    c_msb = full[CHUNK-1] ^ x[CHUNK-1] ^ y[CHUNK-1];
  end

endmodule

// File: rtl/serial_chunk_adder.sv
// Multi-cycle adder/subtractor: adds CHUNK bits per cycle, LSB chunk first,
// with a valid/ready handshake on both the operand and result sides.
module serial_chunk_adder
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned CHUNK = DEFAULT_CHUNK
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int unsigned NCHUNK = WIDTH / CHUNK;
  localparam int unsigned CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] part_q, part_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic [31:0]      base;
  logic [CHUNK-1:0] x_c, y_c, s_c;
  logic             co_c, c_msb_c;

  // Select the active chunk of each stored operand.
  assign base = 32'(cnt_q) * CHUNK;
  assign x_c  = CHUNK'(a_q >> base);
  assign y_c  = CHUNK'(b_q >> base);

  chunk_adder #(.CHUNK(CHUNK)) u_chunk (
    .x     (x_c),
    .y     (y_c),
    .ci    (carry_q),
    .s     (s_c),
    .co    (co_c),
    .c_msb (c_msb_c)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      part_q  <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      part_q  <= part_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    part_d  = part_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          a_d     = a;
          b_d     = sub ? ~b : b;
          carry_d = cin;
          cnt_d   = '0;
          part_d  = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        // Partial result accumulates privately; visible outputs change only at completion.
        part_d  = part_q | (WIDTH'(s_c) << base);
        carry_d = co_c;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          sum_d   = part_d;
          cout_d  = co_c;
          ovf_d   = c_msb_c ^ co_c;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_serial_chunk_adder.sv
// Directed and randomized checks of serial_chunk_adder in three sizings.
module tb_serial_chunk_adder;

  logic clk = 1'b0;
  logic rst = 1'b0;

  // 32/8 instance
  logic        in_valid = 1'b0, in_ready, cin = 1'b0, sub = 1'b0;
  logic [31:0] a = '0, b = '0, sum;
  logic        out_valid, out_ready = 1'b0, cout, overflow;

  // 32/32 instance
  logic        p_in_valid = 1'b0, p_in_ready, p_cin = 1'b0, p_sub = 1'b0;
  logic [31:0] p_a = '0, p_b = '0, p_sum;
  logic        p_out_valid, p_out_ready = 1'b0, p_cout, p_overflow;

  // 12/4 instance
  logic        q_in_valid = 1'b0, q_in_ready, q_cin = 1'b0, q_sub = 1'b0;
  logic [11:0] q_a = '0, q_b = '0, q_sum;
  logic        q_out_valid, q_out_ready = 1'b0, q_cout, q_overflow;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  serial_chunk_adder #(.WIDTH(32), .CHUNK(8)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
    .out_ready(out_ready), .sum(sum), .cout(cout), .overflow(overflow)
  );

  serial_chunk_adder #(.WIDTH(32), .CHUNK(32)) u_p (
    .clk(clk), .rst(rst), .in_valid(p_in_valid), .in_ready(p_in_ready),
    .a(p_a), .b(p_b), .cin(p_cin), .sub(p_sub), .out_valid(p_out_valid),
    .out_ready(p_out_ready), .sum(p_sum), .cout(p_cout), .overflow(p_overflow)
  );

  serial_chunk_adder #(.WIDTH(12), .CHUNK(4)) u_q (
    .clk(clk), .rst(rst), .in_valid(q_in_valid), .in_ready(q_in_ready),
    .a(q_a), .b(q_b), .cin(q_cin), .sub(q_sub), .out_valid(q_out_valid),
    .out_ready(q_out_ready), .sum(q_sum), .cout(q_cout), .overflow(q_overflow)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        sub;
    logic [31:0] s;
    logic        co;
    logic        ov;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Present one operand set on the 32/8 DUT; returns at the negedge after accept.
  task automatic start_op(input logic [31:0] ta, input logic [31:0] tb, input logic tc, input logic ts);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("ready_before_op", 64'(in_ready), 64'd1);
    a = ta; b = tb; cin = tc; sub = ts; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    // Scramble operands to show they are only sampled at accept.
    a = $urandom; b = $urandom; cin = 1'($urandom); sub = 1'($urandom);
  endtask

  task automatic wait_result(output int lat);
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[8];
    int   lat;
    logic seen;

    vecs[0] = '{32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0100, 1'b0, 1'b0};
    vecs[1] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
    vecs[2] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
    vecs[3] = '{32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0};
    vecs[4] = '{32'h0000_0007, 32'h0000_0005, 1'b1, 1'b1, 32'h0000_0002, 1'b1, 1'b0};
    vecs[5] = '{32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1};
    vecs[6] = '{32'h1234_5678, 32'h0FED_CBA8, 1'b1, 1'b0, 32'h2222_2221, 1'b0, 1'b0};
    vecs[7] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1};

    // Reset state
    #2 rst = 1'b1;
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_outputs", {31'd0, cout, overflow, sum}, 64'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);

    // Table-driven functional vectors
    for (int i = 0; i < 8; i++) begin
      start_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub);
      chk("busy_in_ready", 64'(in_ready), 64'd0);
      wait_result(lat);
      chk("latency", 64'(lat), 64'd4);
      chk("sum", 64'(sum), 64'(vecs[i].s));
      chk("cout", 64'(cout), 64'(vecs[i].co));
      chk("overflow", 64'(overflow), 64'(vecs[i].ov));
      release_result();
      chk("idle_after_release", {62'd0, out_valid, in_ready}, 64'd1);
    end

    // Backpressure: hold result 10 cycles, ignore in_valid, then back-to-back op
    start_op(32'd3, 32'd4, 1'b0, 1'b0);
    wait_result(lat);
    chk("hold_latency", 64'(lat), 64'd4);
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      a = 32'd100 + 32'(i); b = 32'd200;
      @(negedge clk);
      chk("hold_state", {31'd0, out_valid, in_ready, sum}, {31'd0, 1'b1, 1'b0, 32'd7});
    end
    a = 32'd10; b = 32'd20; cin = 1'b0; sub = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("return_idle", {62'd0, out_valid, in_ready}, 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("b2b_accepted", 64'(in_ready), 64'd0);
    wait_result(lat);
    chk("b2b_latency", 64'(lat), 64'd4);
    chk("b2b_sum", 64'(sum), 64'd30);
    release_result();

    // Reset while busy discards the operation
    start_op(32'h1111_1111, 32'h2222_2222, 1'b1, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_in_ready", 64'(in_ready), 64'd0);
    chk("midrst_outputs", {31'd0, cout, overflow, sum}, 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst_release_ready", 64'(in_ready), 64'd1);
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    chk("midrst_no_result", 64'(seen), 64'd0);
    start_op(32'd1, 32'd2, 1'b0, 1'b0);
    wait_result(lat);
    chk("after_rst_latency", 64'(lat), 64'd4);
    chk("after_rst_sum", {31'd0, cout, overflow, sum}, 64'd3);
    release_result();

    // Random sweeps of the single-cycle and 12-bit sizings in parallel
    fork
      begin
        logic [31:0] ra, rb, rbe;
        logic        rc, rs, reo;
        logic [32:0] rex;
        int          n;
        for (int i = 0; i < 10000; i++) begin
          ra = $urandom; rb = $urandom; rc = 1'($urandom); rs = 1'($urandom);
          rbe = rs ? ~rb : rb;
          rex = {1'b0, ra} + {1'b0, rbe} + 33'(rc);
          reo = (ra[31] == rbe[31]) && (rex[31] != ra[31]);
          chk("p_ready", 64'(p_in_ready), 64'd1);
          p_a = ra; p_b = rb; p_cin = rc; p_sub = rs; p_in_valid = 1'b1;
          @(negedge clk);
          p_in_valid = 1'b0;
          p_a = $urandom; p_b = $urandom;
          n = 0;
          while (!p_out_valid && n < 20) begin
            @(negedge clk);
            n++;
          end
          chk("p_latency", 64'(n), 64'd1);
          repeat ($urandom_range(0, 1)) @(negedge clk);
          chk("p_result", {30'd0, p_overflow, p_cout, p_sum}, {30'd0, reo, rex});
          p_out_ready = 1'b1;
          @(negedge clk);
          p_out_ready = 1'b0;
        end
      end
      begin
        logic [11:0] qa, qb, qbe;
        logic        qc, qs, qeo;
        logic [12:0] qex;
        int          n;
        for (int i = 0; i < 10000; i++) begin
          qa = 12'($urandom); qb = 12'($urandom); qc = 1'($urandom); qs = 1'($urandom);
          qbe = qs ? ~qb : qb;
          qex = {1'b0, qa} + {1'b0, qbe} + 13'(qc);
          qeo = (qa[11] == qbe[11]) && (qex[11] != qa[11]);
          chk("q_ready", 64'(q_in_ready), 64'd1);
          q_a = qa; q_b = qb; q_cin = qc; q_sub = qs; q_in_valid = 1'b1;
          @(negedge clk);
          q_in_valid = 1'b0;
          q_a = 12'($urandom); q_b = 12'($urandom);
          n = 0;
          while (!q_out_valid && n < 20) begin
            @(negedge clk);
            n++;
          end
          chk("q_latency", 64'(n), 64'd3);
          repeat ($urandom_range(0, 1)) @(negedge clk);
          chk("q_result", {50'd0, q_overflow, q_cout, q_sum}, {50'd0, qeo, qex});
          q_out_ready = 1'b1;
          @(negedge clk);
          q_out_ready = 1'b0;
        end
      end
    join

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_chunk_adder.md
SERIAL_CHUNK_ADDER -- requirements
Module: serial_chunk_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand and result width in bits.
REQ-002 SHALL have parameter CHUNK, default 8: bits added per cycle; WIDTH % CHUNK == 0 and CHUNK <= WIDTH.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  operands on a, b, cin, sub are valid.
REQ-006 SHALL have port in_ready  output  1  block can accept operands.
REQ-007 SHALL have port a  input  WIDTH  first operand.
REQ-008 SHALL have port b  input  WIDTH  second operand.
REQ-009 SHALL have port cin  input  1  carry-in.
REQ-010 SHALL have port sub  input  1  mode: 0 add, 1 subtract (b inverted).
REQ-011 SHALL have port out_valid  output  1  result outputs valid.
REQ-012 SHALL have port out_ready  input  1  consumer accepts result.
REQ-013 SHALL have port sum  output  WIDTH  result.
REQ-014 SHALL have port cout  output  1  carry out of bit WIDTH-1.
REQ-015 SHALL have port overflow  output  1  two's-complement signed overflow.

Function
REQ-016 SHALL compute {cout, sum} = a + (sub ? ~b : b) + cin, modulo 2^(WIDTH+1); a - b requires sub=1, cin=1.
REQ-017 SHALL set overflow = carry into bit WIDTH-1 XOR cout.
REQ-018 SHALL implement FSM states IDLE, BUSY, DONE.
REQ-019 SHALL drive in_ready=1 only in IDLE, out_valid=1 only in DONE.
REQ-020 IDLE: on in_valid & in_ready at a rising edge, SHALL register a, effective b, cin; clear chunk counter; go to BUSY.
REQ-021 BUSY: each rising edge SHALL add chunk k (bits k*CHUNK+CHUNK-1 .. k*CHUNK), LSB chunk first, using the carry registered from chunk k-1 (cin for k=0), and store the partial result and carry.
REQ-022 After chunk NCHUNK-1 (NCHUNK = WIDTH/CHUNK) SHALL go to DONE; latency is exactly NCHUNK edges from accept to out_valid=1.
REQ-023 DONE: sum, cout, overflow SHALL stay stable while out_valid=1 and out_ready=0.
REQ-024 DONE: on out_ready=1 at a rising edge SHALL return to IDLE; the next accept occurs no earlier than the following edge.
REQ-025 in_valid in BUSY/DONE SHALL be ignored; a, b, cin, sub SHALL be sampled only at accept.
REQ-026 CHUNK == WIDTH SHALL give single-cycle BUSY (latency 1).
REQ-027 sum, cout, overflow SHALL hold their last values in IDLE and BUSY; their value is defined only while out_valid=1.

Reset
REQ-028 rst SHALL asynchronously force IDLE, in_ready=1 (after rst deasserts), out_valid=0, sum=0, cout=0, overflow=0, counter=0, carry register=0.
REQ-029 rst asserted mid-BUSY or in DONE SHALL discard the operation; no out_valid results from it.
REQ-030 While rst=1, in_ready SHALL be 0.

Structure
REQ-031 Package adder_pkg SHALL hold the state enum type (IDLE, BUSY, DONE) and the default WIDTH/CHUNK constants.
REQ-032 One sub-module, chunk_adder (parameter CHUNK, inputs x, y, ci, outputs s, co, c_msb, where c_msb is the carry into its MSB), SHALL be instantiated once; the top block holds the FSM, counter, and registers.
REQ-033 Counter width SHALL be $clog2(NCHUNK), minimum 1.

Verification (WIDTH=32, CHUNK=8 unless stated)
REQ-034 a=0x0000_00FF, b=0x0000_0001, cin=0, sub=0 -> exactly 4 edges after accept: out_valid=1, sum=0x0000_0100, cout=0, overflow=0.
REQ-035 a=0xFFFF_FFFF, b=0x0000_0001, cin=0, sub=0 -> sum=0, cout=1, overflow=0; a=0x7FFF_FFFF, b=1 -> sum=0x8000_0000, overflow=1.
REQ-036 sub=1, cin=1, a=5, b=7 -> sum=0xFFFF_FFFE, cout=0; a=7, b=5 -> sum=2, cout=1.
REQ-037 Hold out_ready=0 for 10 cycles in DONE -> outputs stable, in_ready=0, new in_valid ignored; out_ready=1 -> IDLE next edge, back-to-back op accepted the edge after.
REQ-038 Assert rst on 2nd BUSY edge -> immediate IDLE, out_valid=0, outputs 0; the subsequent op with a=1, b=2 returns sum=3.
REQ-039 Run a random sweep of 10k ops with WIDTH=32, CHUNK=32 and with WIDTH=12, CHUNK=4 against a reference model with random out_ready backpressure -> all results match.
